// File: rtl/fuzz_stim_sequencer.sv
// rtl/fuzz_stim_sequencer.sv - LCG stimulus sequencer for the fuzz DUT; FUZZ_SIG_EN adds a response signature
`timescale 1ns/1ps

module fuzz_stim_sequencer #(
    parameter int IN_W    = 135,
    parameter int OUT_W   = 159,
    parameter int CNT_W   = 32,
    parameter int RST_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      cfg_seed,
    input  logic [CNT_W-1:0] cfg_cycles,
    input  logic [OUT_W-1:0] out_flat,
    output logic [IN_W-1:0]  in_flat,
    output logic             dut_rst_n,
    output logic             dut_ce,
    output logic             busy,
    output logic             done,
`ifdef FUZZ_SIG_EN
    output logic [CNT_W-1:0] vec_count,
    output logic [31:0]      sig
`else
    output logic [CNT_W-1:0] vec_count
`endif
);

    localparam int NW   = (IN_W + 31) / 32;
    localparam int WI_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [WI_W-1:0] LAST_WORD = WI_W'(NW - 1);
    localparam logic [RC_W-1:0] LAST_RST  = RC_W'(RST_CYC - 1);
    localparam logic [31:0]     LCG_MUL   = 32'h41C64E6D;
    localparam logic [31:0]     LCG_INC   = 32'h00003039;

    typedef enum logic [2:0] {S_IDLE, S_RESET, S_GEN, S_APPLY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      rng_q, rng_d, rng_nxt;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] vec_count_q, vec_count_d, vec_inc;
    logic [IN_W-1:0]  shadow_q, shadow_d;
    logic [IN_W-1:0]  in_flat_q, in_flat_d;
    logic [WI_W-1:0]  word_q, word_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic             dut_rst_n_q, dut_rst_n_d;
    logic             dut_ce_q, dut_ce_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

`ifdef FUZZ_SIG_EN
    logic [31:0] sig_q, sig_d, fold;

    // Fold the whole response into one word: bit i lands in lane i mod 32
    always_comb begin
        fold = '0;
        for (int i = 0; i < OUT_W; i++) begin
            fold[i % 32] = fold[i % 32] ^ out_flat[i];
        end
    end
`else
    logic unused_out_flat;
    assign unused_out_flat = ^out_flat;
`endif

    // Next-state, datapath and registered-output computation
    always_comb begin
        rng_nxt     = rng_q * LCG_MUL + LCG_INC;
        vec_inc     = vec_count_q + CNT_W'(1);
        state_d     = state_q;
        rng_d       = rng_q;
        n_d         = n_q;
        vec_count_d = vec_count_q;
        shadow_d    = shadow_q;
        in_flat_d   = in_flat_q;
        word_d      = word_q;
        rst_cnt_d   = rst_cnt_q;
`ifdef FUZZ_SIG_EN
        sig_d       = sig_q;
`endif
        if (abort) begin
            // abort freezes counters and signature; only the state returns to IDLE
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rng_d       = cfg_seed;
                        n_d         = cfg_cycles;
                        vec_count_d = '0;
                        word_d      = '0;
                        rst_cnt_d   = '0;
`ifdef FUZZ_SIG_EN
                        sig_d       = '0;
`endif
                        state_d     = S_RESET;
                    end
                end
                S_RESET: begin
                    if (rst_cnt_q == LAST_RST) begin
                        state_d = (n_q == '0) ? S_DONE : S_GEN;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RC_W'(1);
                    end
                end
                S_GEN: begin
                    rng_d = rng_nxt;
                    for (int i = 0; i < IN_W; i++) begin
                        if (word_q == WI_W'(i / 32)) begin
                            shadow_d[i] = rng_nxt[i % 32];
                        end
                    end
                    if (word_q == LAST_WORD) begin
                        // publish the full vector together with the ce pulse
                        word_d    = '0;
                        in_flat_d = shadow_d;
                        state_d   = S_APPLY;
                    end else begin
                        word_d = word_q + WI_W'(1);
                    end
                end
                S_APPLY: begin
                    vec_count_d = vec_inc;
`ifdef FUZZ_SIG_EN
                    sig_d       = {sig_q[30:0], sig_q[31]} ^ fold;
`endif
                    state_d     = (vec_inc == n_q) ? S_DONE : S_GEN;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        dut_rst_n_d = (state_d == S_GEN) || (state_d == S_APPLY) || (state_d == S_DONE);
        dut_ce_d    = (state_d == S_APPLY);
        busy_d      = (state_d == S_RESET) || (state_d == S_GEN) || (state_d == S_APPLY);
        done_d      = (state_d == S_DONE);
    end

    // Single register stage for state, datapath and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rng_q       <= '0;
            n_q         <= '0;
            vec_count_q <= '0;
            shadow_q    <= '0;
            in_flat_q   <= '0;
            word_q      <= '0;
            rst_cnt_q   <= '0;
            dut_rst_n_q <= 1'b0;
            dut_ce_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef FUZZ_SIG_EN
            sig_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rng_q       <= rng_d;
            n_q         <= n_d;
            vec_count_q <= vec_count_d;
            shadow_q    <= shadow_d;
            in_flat_q   <= in_flat_d;
            word_q      <= word_d;
            rst_cnt_q   <= rst_cnt_d;
            dut_rst_n_q <= dut_rst_n_d;
            dut_ce_q    <= dut_ce_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef FUZZ_SIG_EN
            sig_q       <= sig_d;
`endif
        end
    end

    assign in_flat   = in_flat_q;
    assign dut_rst_n = dut_rst_n_q;
    assign dut_ce    = dut_ce_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign vec_count = vec_count_q;
`ifdef FUZZ_SIG_EN
    assign sig       = sig_q;
`endif

endmodule
